// File: rtl/mvau_weight_stream.sv
// ---------------------------------------------------------------------------
// mvau_weight_stream : weight-memory read sequencer with a credit-gated 2-entry
// output FIFO, presenting NUM_REPS full memory sweeps as a valid/ready stream.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mvau_weight_stream #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4,
  parameter int NUM_REPS     = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [WMEM_ADDR_BW-1:0] wmem_addr,
  input  logic [SIMD*TW-1:0]      wmem_out,
  output logic                    out_v,
  input  logic                    out_rdy,
  output logic [SIMD*TW-1:0]      out_wgt,
  output logic                    out_last
);

  localparam int WW     = SIMD * TW;
  localparam int REP_BW = (NUM_REPS > 1) ? $clog2(NUM_REPS) : 1;
  localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);
  localparam logic [REP_BW-1:0]       LAST_REP  = REP_BW'(NUM_REPS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [WMEM_ADDR_BW-1:0] addr_q, addr_d;
  logic [REP_BW-1:0]       rep_q, rep_d;
  logic                    inflight_q, inflight_d;
  logic                    infl_last_q, infl_last_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [WW:0]             head_q, head_d;
  logic [WW:0]             tail_q, tail_d;

  logic       pop;
  logic       issue;
  logic       drained;
  logic [2:0] credit;
  logic [WW:0] push_ent;

  assign out_v     = (cnt_q != 2'd0);
  assign out_wgt   = head_q[WW-1:0];
  assign out_last  = out_v & head_q[WW];
  assign wmem_addr = addr_q;

  assign pop      = out_v & out_rdy;
  assign push_ent = {infl_last_q, wmem_out};
  // Words already held plus the one read still in the memory pipe must leave room.
  assign credit   = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue    = (state_q == S_RUN) && (credit < 3'd2);
  assign drained  = (cnt_q == 2'd0) && !inflight_q;
  assign busy     = (state_q == S_RUN) || ((state_q == S_DRAIN) && !drained);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rep_d       = rep_q;
    done        = 1'b0;
    inflight_d  = issue;
    infl_last_d = (addr_q == LAST_ADDR);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          addr_d  = '0;
          rep_d   = '0;
        end
      end
      S_RUN: begin
        if (issue) begin
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            if (rep_q == LAST_REP) begin
              rep_d   = '0;
              state_d = S_DRAIN;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drained) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({inflight_q, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = push_ent;
        else               tail_d = push_ent;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = push_ent;
        end else begin
          head_d = push_ent;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rep_q       <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      cnt_q       <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rep_q       <= rep_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      cnt_q       <= cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mvau_weight_stream.sv
// ---------------------------------------------------------------------------
// tb_mvau_weight_stream : self-checking bench for mvau_weight_stream.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mvau_weight_stream;

  localparam int DEPTH = 4;
  localparam int REPS  = 4;
  localparam int TOTAL = DEPTH * REPS;

  logic       aclk = 1'b0;
  logic       areset;
  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] wmem_addr;
  logic [1:0] wmem_out;
  logic       out_v;
  logic       out_rdy;
  logic [1:0] out_wgt;
  logic       out_last;

  logic [1:0] mem [0:DEPTH-1];
  int checks   = 0;
  int failures = 0;

  mvau_weight_stream #(
    .SIMD(2), .TW(1), .WMEM_DEPTH(DEPTH), .WMEM_ADDR_BW(4), .NUM_REPS(REPS)
  ) dut (
    .aclk(aclk), .areset(areset), .start(start), .busy(busy), .done(done),
    .wmem_addr(wmem_addr), .wmem_out(wmem_out), .out_v(out_v), .out_rdy(out_rdy),
    .out_wgt(out_wgt), .out_last(out_last)
  );

  always #5 aclk = ~aclk;

  // Registered-read weight memory: data for the sampled address appears next cycle.
  always @(posedge aclk) wmem_out <= mem[wmem_addr[1:0]];

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // One complete run against a queue of expected {word,last} in sweep order.
  // pct: out_rdy probability; stall: out_rdy forced low for this many cycles;
  // abort_at: return once this many words were accepted (0 = run to done).
  task automatic run(input int pct, input int stall, input int abort_at);
    logic [1:0] q_w[$];
    bit         q_l[$];
    int         accepted = 0;
    int         issued   = 0;
    int         last_x   = -10;
    logic [3:0] prev_addr;
    bit         pv = 0, pr = 0, pl = 0, seen_v = 0, finished = 0;
    logic [1:0] pw = '0;
    for (int r = 0; r < REPS; r++)
      for (int a = 0; a < DEPTH; a++) begin
        q_w.push_back(mem[a]);
        q_l.push_back(a == DEPTH - 1);
      end
    @(posedge aclk); #1;
    start     = 1'b1;
    out_rdy   = (stall > 0) ? 1'b0 : ($urandom_range(99) < pct);
    prev_addr = wmem_addr;
    for (int c = 0; c < 400 && !finished; c++) begin
      if (c > 0) begin
        @(posedge aclk); #1;
        start   = 1'b0;
        out_rdy = (c < stall) ? 1'b0 : ($urandom_range(99) < pct);
      end
      @(negedge aclk);
      if (wmem_addr != prev_addr) issued++;
      prev_addr = wmem_addr;
      chk(issued - accepted <= 2, "run_issue_ahead", issued - accepted, 2);
      if (pv && !pr)
        chk(out_v && out_wgt == pw && out_last == pl, "run_stall_hold", int'(out_wgt), int'(pw));
      if (stall > 0 && c == stall) begin
        chk(out_v == 1'b1, "stall_out_v", out_v, 1);
        chk(out_wgt == mem[0], "stall_head_word", int'(out_wgt), int'(mem[0]));
        chk(wmem_addr == 4'd2, "stall_addr", int'(wmem_addr), 2);
        chk(issued == 2, "stall_issues", issued, 2);
      end
      if (out_v && !seen_v && stall == 0)
        chk(c == 3, "first_word_latency", c, 3);
      if (pct == 100 && seen_v && c >= stall && accepted < TOTAL)
        chk(out_v == 1'b1, "no_bubble", out_v, 1);
      if (out_v) seen_v = 1;
      if (done) begin
        chk(q_w.size() == 0, "done_all_words", TOTAL - q_w.size(), TOTAL);
        chk(issued == TOTAL, "done_issue_count", issued, TOTAL);
        chk(c == last_x + 1, "done_timing", c, last_x + 1);
        chk(busy == 1'b0, "done_busy_low", busy, 0);
        finished = 1;
      end
      if (out_v && out_rdy) begin
        if (q_w.size() == 0) begin
          chk(0, "extra_word", accepted + 1, TOTAL);
        end else begin
          chk(out_wgt == q_w[0], "word_order", int'(out_wgt), int'(q_w[0]));
          chk(out_last == q_l[0], "word_last", out_last, q_l[0]);
          void'(q_w.pop_front());
          void'(q_l.pop_front());
        end
        accepted++;
        last_x = c;
        if (abort_at > 0 && accepted == abort_at) finished = 1;
      end
      pv = out_v; pr = out_rdy; pw = out_wgt; pl = out_last;
    end
    chk(finished, "run_timeout", finished, 1);
    start   = 1'b0;
    out_rdy = 1'b0;
  endtask

  typedef struct {
    bit         start;
    bit         rdy;
    bit         v;
    logic [1:0] w;
    bit         last;
    bit         busy;
    bit         done;
    logic [3:0] addr;
  } vec_t;

  vec_t tbl [22];

  initial begin
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3; mem[3] = 2'd1;
    // Stream with out_rdy held high; extra starts during RUN and in the done cycle.
    for (int c = 0; c < 22; c++) begin
      tbl[c].start = (c == 0) || (c == 5) || (c == 19);
      tbl[c].rdy   = 1'b1;
      tbl[c].v     = (c >= 3) && (c <= 18);
      tbl[c].w     = tbl[c].v ? mem[(c - 3) % DEPTH] : 2'd0;
      tbl[c].last  = tbl[c].v && ((c - 3) % DEPTH == DEPTH - 1);
      tbl[c].busy  = (c >= 1) && (c <= 18);
      tbl[c].done  = (c == 19);
      tbl[c].addr  = ((c >= 1) && (c <= 17)) ? 4'((c - 1) % DEPTH) : 4'd0;
    end

    areset = 1'b1; start = 1'b0; out_rdy = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk(out_v == 0 && busy == 0 && done == 0, "reset_ctrl", {out_v, busy, done}, 0);
    chk(wmem_addr == 0 && out_last == 0, "reset_addr_last", int'(wmem_addr), 0);
    areset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      chk(out_v == 0 && busy == 0, "idle_no_output", {out_v, busy}, 0);
    end
    @(posedge aclk); #3;
    areset = 1'b1;
    #1;
    chk(out_v == 0 && busy == 0 && done == 0 && wmem_addr == 0, "midcycle_reset",
        {out_v, busy, done}, 0);
    @(posedge aclk); #1;
    areset = 1'b0;

    for (int c = 0; c < 22; c++) begin
      @(posedge aclk); #1;
      start   = tbl[c].start;
      out_rdy = tbl[c].rdy;
      @(negedge aclk);
      chk(out_v == tbl[c].v, $sformatf("tbl_out_v@%0d", c), out_v, tbl[c].v);
      chk(busy == tbl[c].busy, $sformatf("tbl_busy@%0d", c), busy, tbl[c].busy);
      chk(done == tbl[c].done, $sformatf("tbl_done@%0d", c), done, tbl[c].done);
      chk(wmem_addr == tbl[c].addr, $sformatf("tbl_addr@%0d", c), int'(wmem_addr), int'(tbl[c].addr));
      chk(out_last == tbl[c].last, $sformatf("tbl_last@%0d", c), out_last, tbl[c].last);
      if (tbl[c].v)
        chk(out_wgt == tbl[c].w, $sformatf("tbl_word@%0d", c), int'(out_wgt), int'(tbl[c].w));
    end
    start = 1'b0;

    run(50, 0, 0);
    run(100, 6, 0);

    run(100, 0, 7);
    #2;
    areset = 1'b1;
    #1;
    chk(out_v == 0 && busy == 0 && done == 0 && wmem_addr == 0 && out_last == 0,
        "midrun_reset", {out_v, busy, done, out_last}, 0);
    @(posedge aclk); #1;
    areset = 1'b0;
    run(100, 0, 0);

    for (int k = 0; k < 4; k++) begin
      for (int a = 0; a < DEPTH; a++) mem[a] = 2'($urandom);
      run($urandom_range(20, 80), 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
